// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: N-digit BCD up/down counter with clamped parallel load,
// wrap or saturate behaviour at the range ends and a cascade carry.
module bcd_counter_ndigit #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  carry_out,
    output logic                  wrap,
    output logic                  load_err
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]      r_count;
    logic              r_wrap;
    logic              r_load_err;
    logic [W-1:0]      w_step;
    logic [W-1:0]      w_ld;
    logic [DIGITS-1:0] w_bad;
    logic              w_tc;
    logic              w_chain [DIGITS+1];

    // w_chain[i]: all digits below i sit at the end value for this direction
    assign w_chain[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            logic [3:0] w_d;
            logic [3:0] w_v;
            logic [3:0] w_inc;
            logic [3:0] w_dec;
            assign w_d   = r_count[4*g +: 4];
            assign w_v   = load_val[4*g +: 4];
            assign w_inc = (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
            assign w_dec = (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;
            assign w_chain[g+1] = w_chain[g] &
                (up ? (w_d == 4'd9) : (w_d == 4'd0));
            assign w_step[4*g +: 4] = !w_chain[g] ? w_d :
                                      (up ? w_inc : w_dec);
            assign w_bad[g] = (w_v > 4'd9);
            assign w_ld[4*g +: 4] = w_bad[g] ? 4'd9 : w_v;
        end
    endgenerate

    assign w_tc = w_chain[DIGITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (clr) begin
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_count    <= w_ld;
            r_wrap     <= 1'b0;
            r_load_err <= |w_bad;
        end else if (en) begin
            // at the limit the full step already yields all-0 / all-9
            if (w_tc && !WRAP) begin
                r_count <= r_count;
            end else begin
                r_count <= w_step;
            end
            r_wrap     <= w_tc;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end
    end

    assign count     = r_count;
    assign wrap      = r_wrap;
    assign load_err  = r_load_err;
    assign tc        = w_tc;
    assign carry_out = en & w_tc & ~clr & ~load;

endmodule
